// File: rtl/motor_pkg.sv
// Shared types and constants for the stepper move controller.
package motor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // One-hot coil patterns, phase A first in the forward direction.
    localparam logic [3:0] FASE_A   = 4'b1000;
    localparam logic [3:0] FASE_B   = 4'b0100;
    localparam logic [3:0] FASE_C   = 4'b0010;
    localparam logic [3:0] FASE_D   = 4'b0001;
    localparam logic [3:0] COIL_OFF = 4'b0000;

    // Phase index to coil pattern.
    function automatic logic [3:0] idx_to_coil(input logic [1:0] idx);
        logic [3:0] pattern;
        case (idx)
            2'd0:    pattern = FASE_A;
            2'd1:    pattern = FASE_B;
            2'd2:    pattern = FASE_C;
            default: pattern = FASE_D;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/fase_motor.sv
// Phase sequencer: keeps the 2-bit phase index across moves and decodes
// the coil drive from it. Coils are dark whenever energize is low.
module fase_motor
    import motor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       energize,
    output logic [1:0] idx,
    output logic [3:0] coil
);

    // Advance or retreat one phase per step strobe, wrapping mod 4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 2'd0;
        end else if (step) begin
            idx <= dir ? (idx + 2'd1) : (idx - 2'd1);
        end
    end

    // Coil drive decoded only from registers (index and energize flag).
    assign coil = energize ? idx_to_coil(idx) : COIL_OFF;

endmodule

// File: rtl/controlador_motor.sv
// Move controller for a 4-coil unipolar stepper.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and cmd_* are
// ignored at all other times.
module controlador_motor
    import motor_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DIV_W    = 16,
    parameter int HOLD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left,
    output logic [3:0]       coil,
    output state_t           dbg_state
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    state_t             state;
    logic               dir_q;
    logic [DIV_W-1:0]   period_m1;
    logic [DIV_W-1:0]   timer;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DIV_W-1:0]   period_eff;
    logic               strobe;
    logic               energize;
    logic [1:0]         idx;

    // A zero period behaves as one cycle per step.
    assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    // Step strobe fires when the timer expires in RUN; an abort in the
    // same cycle swallows it so the phase does not move.
    assign strobe   = (state == S_RUN) && (timer == '0) && !abort;
    assign energize = (state != S_IDLE);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Move FSM with period timer, step counter and hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            dir_q      <= 1'b0;
            period_m1  <= '0;
            timer      <= '0;
            steps_left <= '0;
            hold_cnt   <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dir_q      <= cmd_dir;
                        period_m1  <= period_eff - DIV_W'(1);
                        timer      <= period_eff - DIV_W'(1);
                        steps_left <= cmd_steps;
                        if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (timer == '0) begin
                        timer      <= period_m1;
                        steps_left <= steps_left - CNT_W'(1);
                        if (steps_left == CNT_W'(1)) begin
                            state    <= S_HOLD;
                            hold_cnt <= HOLD_W'(HOLD_CYC - 1);
                        end
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (hold_cnt == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fase_motor u_fase (
        .clk      (clk),
        .rst      (rst),
        .step     (strobe),
        .dir      (dir_q),
        .energize (energize),
        .idx      (idx),
        .coil     (coil)
    );

endmodule

// File: tb/tb_controlador_motor.sv
// Bench for controlador_motor: directed scenarios plus random moves,
// checked every cycle against a cycle-count model of a move.
module tb_controlador_motor;
    import motor_pkg::*;

    localparam int CNT_W    = 16;
    localparam int DIV_W    = 16;
    localparam int HOLD_CYC = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] steps_left;
    logic [3:0]       coil;
    state_t           dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // Model state carried between moves.
    int m_idx        = 0;
    int m_steps_left = 0;

    controlador_motor #(
        .CNT_W    (CNT_W),
        .DIV_W    (DIV_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left),
        .coil       (coil),
        .dbg_state  (dbg_state)
    );

    // Clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return mid-cycle (falling edge) for drive and sample.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] base;
        base = 4'b1000;
        return base >> (i & 3);
    endfunction

    task automatic check_outputs(input logic [3:0] e_coil, input logic e_busy,
                                 input logic e_done, input logic e_abt,
                                 input int e_left, input logic e_rdy);
        check("coil",       {28'd0, coil},       {28'd0, e_coil});
        check("busy",       {31'd0, busy},       {31'd0, e_busy});
        check("done",       {31'd0, done},       {31'd0, e_done});
        check("aborted",    {31'd0, aborted},    {31'd0, e_abt});
        check("steps_left", {16'd0, steps_left}, e_left);
        check("cmd_ready",  {31'd0, cmd_ready},  {31'd0, e_rdy});
    endtask

    // Offer one command in the current (idle) cycle and follow it to its
    // done cycle. Cycle c of a move with period P has taken floor((c-1)/P)
    // steps (capped at N); abort_at=0 means no abort.
    task automatic run_cmd(input logic d, input int n, input int p,
                           input int abort_at, input logic idle_abort);
        int pe;
        int fin;
        int taken;
        pe = (p == 0) ? 1 : p;
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = 16'(n);
        cmd_period = 16'(p);
        abort      = idle_abort;
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        if (n == 0) begin
            m_steps_left = 0;
            check_outputs(4'b0000, 1'b0, 1'b1, 1'b0, 0, 1'b1);
            return;
        end
        fin = (abort_at > 0) ? abort_at + 1 : n * pe + HOLD_CYC + 1;
        for (int c = 1; c < fin; c++) begin
            taken = (c - 1) / pe;
            if (taken > n) taken = n;
            check_outputs(onehot(m_idx + (d ? taken : -taken)), 1'b1, 1'b0, 1'b0,
                          n - taken, 1'b0);
            abort      = (c == abort_at);
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_dir    = 1'($urandom);
            cmd_steps  = 16'($urandom);
            cmd_period = 16'($urandom);
            tick();
            abort = 1'b0;
        end
        cmd_valid = 1'b0;
        if (abort_at > 0) begin
            taken = (abort_at - 1) / pe;
            if (taken > n) taken = n;
        end else begin
            taken = n;
        end
        m_idx        = (m_idx + (d ? taken : -taken)) & 3;
        m_steps_left = n - taken;
        check_outputs(4'b0000, 1'b0, 1'b1, (abort_at > 0), m_steps_left, 1'b1);
    endtask

    // Idle cycles; a stray abort here must do nothing.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            abort = 1'($urandom_range(0, 1));
            tick();
            abort = 1'b0;
            check_outputs(4'b0000, 1'b0, 1'b0, 1'b0, m_steps_left, 1'b1);
        end
    endtask

    initial begin
        int n;
        int p;
        int pe;
        int ja;
        logic d;

        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;

        // Reset values before any clock edge.
        #1;
        check_outputs(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Forward 3 steps, period 4.
        run_cmd(1'b1, 3, 4, 0, 1'b0);
        idle(1);
        // Reverse 2 steps, period 0; abort coinciding with accept is ignored.
        run_cmd(1'b0, 2, 0, 0, 1'b1);
        idle(1);
        // Zero-step command.
        run_cmd(1'b1, 0, 5, 0, 1'b0);
        idle(1);
        // Abort on the cycle-6 strobe of a 10-step, period-3 move.
        run_cmd(1'b1, 10, 3, 6, 1'b0);
        idle(1);
        // Back-to-back: second command accepted in the done cycle.
        run_cmd(1'b0, 2, 2, 0, 1'b0);
        run_cmd(1'b1, 1, 1, 0, 1'b0);
        // Abort during HOLD.
        run_cmd(1'b1, 2, 1, 4, 1'b0);
        idle(1);

        // Asynchronous reset in the middle of RUN.
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 16'd8;
        cmd_period = 16'd2;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        check_outputs(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        rst          = 1'b1;
        m_idx        = 0;
        m_steps_left = 0;
        idle(2);

        // Random moves, sometimes aborted, sometimes back-to-back.
        for (int t = 0; t < 25; t++) begin
            d  = 1'($urandom);
            n  = $urandom_range(0, 6);
            p  = $urandom_range(0, 4);
            pe = (p == 0) ? 1 : p;
            ja = 0;
            if (n > 0 && $urandom_range(0, 3) == 0)
                ja = $urandom_range(1, n * pe + HOLD_CYC);
            run_cmd(d, n, p, ja, 1'($urandom));
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
